// File: rtl/transmitter.sv
// Serial byte transmitter: start bit, 8 data bits LSB first, optional even parity, 1-2 stop bits.
// A one-byte holding register lets the next frame follow the current one with no idle gap.
module transmitter #(
  parameter int PARITY_EN = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk_115200hz,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       send,
  output logic       out,
  output logic       ready,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic STOP_LAST = (STOP_BITS == 2);

  state_t     state, state_next;
  logic [7:0] shift_reg, shift_next;
  logic [7:0] hold_reg, hold_next;
  logic       full, full_next;
  logic [2:0] bit_cnt, bit_cnt_next;
  logic       stop_cnt, stop_cnt_next;
  logic       out_next, done_next;
  logic       accept, last_stop;

  assign ready     = ~full;
  assign busy      = (state != IDLE) | full;
  assign accept    = send & ~full;
  assign last_stop = (state == STOP) && (stop_cnt == STOP_LAST);

  always_comb begin
    state_next    = state;
    shift_next    = shift_reg;
    hold_next     = hold_reg;
    full_next     = full;
    bit_cnt_next  = bit_cnt;
    stop_cnt_next = stop_cnt;
    out_next      = 1'b1;
    done_next     = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          shift_next = data;
          state_next = START;
          out_next   = 1'b0;
        end
      end
      START: begin
        state_next   = DATA;
        bit_cnt_next = 3'd0;
        out_next     = shift_reg[0];
      end
      DATA: begin
        bit_cnt_next = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          if (PARITY_EN != 0) begin
            state_next = PARITY;
            out_next   = ^shift_reg;
          end else begin
            state_next    = STOP;
            stop_cnt_next = 1'b0;
          end
        end else begin
          out_next = shift_reg[bit_cnt + 3'd1];
        end
      end
      PARITY: begin
        state_next    = STOP;
        stop_cnt_next = 1'b0;
      end
      STOP: begin
        if (!last_stop) begin
          stop_cnt_next = stop_cnt + 1'b1;
        end else begin
          // End of frame: the held byte wins, else a same-edge send chains directly.
          done_next     = 1'b1;
          stop_cnt_next = 1'b0;
          if (full) begin
            shift_next = hold_reg;
            full_next  = 1'b0;
            state_next = START;
            out_next   = 1'b0;
          end else if (send) begin
            shift_next = data;
            state_next = START;
            out_next   = 1'b0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (accept && (state != IDLE) && !last_stop) begin
      hold_next = data;
      full_next = 1'b1;
    end
  end

  always_ff @(posedge clk_115200hz or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= 8'h00;
      hold_reg  <= 8'h00;
      full      <= 1'b0;
      bit_cnt   <= 3'd0;
      stop_cnt  <= 1'b0;
      out       <= 1'b1;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      shift_reg <= shift_next;
      hold_reg  <= hold_next;
      full      <= full_next;
      bit_cnt   <= bit_cnt_next;
      stop_cnt  <= stop_cnt_next;
      out       <= out_next;
      done      <= done_next;
    end
  end

endmodule

// File: tb/tb_transmitter.sv
// Self-checking bench: three transmitter configurations share one stimulus stream and are
// each compared every clock against a frame-level model (bit queue plus holding byte).
module tb_transmitter;

  logic       clk;
  logic       reset;
  logic [7:0] data;
  logic       send;
  logic [2:0] out_w, ready_w, busy_w, done_w;

  int cfg_pe [3] = '{0, 1, 0};
  int cfg_sb [3] = '{1, 1, 2};

  // Model state per instance: remaining line bits (bit 0 is on the line now) and held byte.
  logic [15:0] line_bits [3];
  int          line_len  [3];
  bit          held_v    [3];
  logic [7:0]  held_b    [3];
  bit          exp_done  [3];

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  transmitter #(.PARITY_EN(0), .STOP_BITS(1)) dut0 (
    .clk_115200hz(clk), .reset(reset), .data(data), .send(send),
    .out(out_w[0]), .ready(ready_w[0]), .busy(busy_w[0]), .done(done_w[0]));
  transmitter #(.PARITY_EN(1), .STOP_BITS(1)) dut1 (
    .clk_115200hz(clk), .reset(reset), .data(data), .send(send),
    .out(out_w[1]), .ready(ready_w[1]), .busy(busy_w[1]), .done(done_w[1]));
  transmitter #(.PARITY_EN(0), .STOP_BITS(2)) dut2 (
    .clk_115200hz(clk), .reset(reset), .data(data), .send(send),
    .out(out_w[2]), .ready(ready_w[2]), .busy(busy_w[2]), .done(done_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cycle, actual, expected);
    end
  endtask

  function automatic logic [15:0] make_frame(input int pe, input logic [7:0] d);
    logic [15:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int k = 0; k < 8; k++) f[1+k] = d[k];
    if (pe != 0) f[9] = ^d;
    return f;
  endfunction

  task automatic clearModel();
    for (int i = 0; i < 3; i++) begin
      line_bits[i] = '1;
      line_len[i]  = 0;
      held_v[i]    = 1'b0;
      held_b[i]    = 8'h00;
      exp_done[i]  = 1'b0;
    end
  endtask

  // Advance one instance's model across a clock edge with the given inputs.
  task automatic modelStep(input int i, input logic s, input logic [7:0] d);
    bit was_idle, ending, acc;
    int flen;
    was_idle = (line_len[i] == 0);
    ending   = (line_len[i] == 1);
    acc      = s && !held_v[i];
    flen     = 9 + cfg_pe[i] + cfg_sb[i];
    exp_done[i] = ending;
    if (!was_idle) begin
      line_bits[i] = {1'b1, line_bits[i][15:1]};
      line_len[i]--;
    end
    if (was_idle) begin
      if (acc) begin
        line_bits[i] = make_frame(cfg_pe[i], d);
        line_len[i]  = flen;
      end
    end else if (ending) begin
      if (held_v[i]) begin
        line_bits[i] = make_frame(cfg_pe[i], held_b[i]);
        line_len[i]  = flen;
        held_v[i]    = 1'b0;
      end else if (acc) begin
        line_bits[i] = make_frame(cfg_pe[i], d);
        line_len[i]  = flen;
      end
    end else if (acc) begin
      held_v[i] = 1'b1;
      held_b[i] = d;
    end
  endtask

  task automatic checkAll();
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("out%0d", i), int'(out_w[i]),
                  (line_len[i] > 0) ? int'(line_bits[i][0]) : 1);
      checkOutput($sformatf("done%0d", i), int'(done_w[i]), int'(exp_done[i]));
      checkOutput($sformatf("ready%0d", i), int'(ready_w[i]), int'(!held_v[i]));
      checkOutput($sformatf("busy%0d", i), int'(busy_w[i]),
                  int'((line_len[i] > 0) || held_v[i]));
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [7:0] d);
    @(negedge clk);
    send = s;
    data = d;
    for (int i = 0; i < 3; i++) modelStep(i, s, d);
    @(posedge clk);
    #1;
    cycle++;
    checkAll();
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 8'($urandom));
  endtask

  // Assert reset between edges and check the line reacts before any clock.
  task automatic asyncReset();
    #2;
    reset = 1'b1;
    send  = 1'b0;
    #1;
    clearModel();
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("rst_out%0d", i), int'(out_w[i]), 1);
      checkOutput($sformatf("rst_ready%0d", i), int'(ready_w[i]), 1);
      checkOutput($sformatf("rst_busy%0d", i), int'(busy_w[i]), 0);
      checkOutput($sformatf("rst_done%0d", i), int'(done_w[i]), 0);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int first_done, gap;
    reset = 1'b1;
    send  = 1'b0;
    data  = 8'h00;
    clearModel();
    #3;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("init_out%0d", i), int'(out_w[i]), 1);
      checkOutput($sformatf("init_ready%0d", i), int'(ready_w[i]), 1);
      checkOutput($sformatf("init_busy%0d", i), int'(busy_w[i]), 0);
      checkOutput($sformatf("init_done%0d", i), int'(done_w[i]), 0);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] single frames 0x55 / 0xA5 / 0xFF");
    applyStimulus(1'b1, 8'h55);
    idleCycles(14);
    applyStimulus(1'b1, 8'hA5);
    idleCycles(14);
    applyStimulus(1'b1, 8'hFF);
    idleCycles(14);

    $display("[TB] back-to-back via holding register, third send ignored");
    first_done = -1;
    gap        = -1;
    applyStimulus(1'b1, 8'h01);
    applyStimulus(1'b0, 8'h33);
    applyStimulus(1'b1, 8'h80);
    applyStimulus(1'b0, 8'h44);
    applyStimulus(1'b1, 8'h77);
    for (int k = 0; k < 22; k++) begin
      applyStimulus(1'b0, 8'($urandom));
      if (done_w[0]) begin
        if (first_done < 0) first_done = cycle;
        else if (gap < 0) gap = cycle - first_done;
      end
    end
    checkOutput("b2b_done_gap", gap, 10);

    $display("[TB] same-edge send at end of frame");
    applyStimulus(1'b1, 8'hC3);
    idleCycles(8);
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 8'h5A);
    applyStimulus(1'b0, 8'h00);
    idleCycles(26);

    $display("[TB] reset mid-frame then recovery");
    applyStimulus(1'b1, 8'h00);
    idleCycles(5);
    asyncReset();
    idleCycles(2);
    applyStimulus(1'b1, 8'h3C);
    idleCycles(14);

    $display("[TB] randomized traffic");
    for (int k = 0; k < 400; k++) begin
      applyStimulus($urandom_range(0, 3) == 0, 8'($urandom));
    end
    idleCycles(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
